shift_add_recombiner: RTL and testbench

Sequential shift-add unit that runs the divider's operation in reverse. It takes a quotient, divisor and remainder and rebuilds the dividend as w = quo*d + rem.
- Used in the divider subsystem as an on-line result checker.
- Also usable as a stand-alone small multiplier by tying rem to 0.
- Same controller/datapath split and start/done handshake as the divider.

---
 rtl/shift_add_recombiner_pkg.sv | 27 ++
 rtl/shift_add_recombiner_if.sv | 22 ++
 rtl/shift_add_recombiner_controller.sv | 86 ++++++++
 rtl/shift_add_recombiner_datapath.sv | 70 +++++++
 rtl/shift_add_recombiner.sv | 48 ++++
 tb/tb_shift_add_recombiner.sv | 228 ++++++++++++++++++++++
 6 files changed

// File: rtl/shift_add_recombiner_pkg.sv
// Shared encodings and width helpers for the shift-add recombiner.
package recomb_pkg;

   localparam int QW_DEF = 5;
   localparam int DW_DEF = 5;
   localparam int RW_DEF = 6;
   localparam int WW_DEF = 10;

   // Encodings double as the pss debug code.
   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_LOAD = 4'd1,
      S_CALC = 4'd2,
      S_DONE = 4'd3
   } state_t;

   // Accumulator must hold quo*d + rem without wrapping.
   function automatic int acc_width(input int qw, input int dw, input int rw);
      return (((qw + dw) > rw) ? (qw + dw) : rw) + 1;
   endfunction

   // Counter has to reach QW-1.
   function automatic int cnt_width(input int qw);
      return (qw < 2) ? 1 : $clog2(qw + 1);
   endfunction

endpackage

// File: rtl/shift_add_recombiner_if.sv
// Operand/result bundle with start/done handshake.
interface shift_add_recombiner_if
   import recomb_pkg::*;
#(
   parameter int QW = QW_DEF,
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF,
   parameter int WW = WW_DEF
);
   logic          start;
   logic [QW-1:0] quo;
   logic [DW-1:0] d;
   logic [RW-1:0] rem;
   logic [WW-1:0] w;
   logic          ov;
   logic          done;
   logic          busy;
   logic [3:0]    pss;

   modport master (output start, quo, d, rem, input w, ov, done, busy, pss);
   modport slave  (input start, quo, d, rem, output w, ov, done, busy, pss);
endinterface

// File: rtl/shift_add_recombiner_controller.sv
// Sequencing FSM for the recombiner.
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | capture quo/d/rem into the datapath
//   CALC  | QW shift-add steps
//   DONE  | latch w/ov; done pulses in the following cycle
module recomb_controller
   import recomb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic       i_co,
   input  logic       i_q0,
   output logic       o_ld,
   output logic       o_add_en,
   output logic       o_sh,
   output logic       o_cnt_en,
   output logic       o_ldout,
   output logic       o_done,
   output logic       o_busy,
   output logic [3:0] o_pss
);
   state_t r_state;
   logic   r_ld, r_sh, r_cnt_en, r_ldout, r_done, r_busy;

   assign o_ld     = r_ld;
   assign o_sh     = r_sh;
   assign o_cnt_en = r_cnt_en;
   assign o_ldout  = r_ldout;
   assign o_done   = r_done;
   assign o_busy   = r_busy;
   assign o_pss    = r_state;
   // The add decision depends on the live multiplier LSB, so it cannot be registered ahead.
   assign o_add_en = r_sh & i_q0;

   // State transitions with outputs registered for the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_ld     <= 1'b0;
         r_sh     <= 1'b0;
         r_cnt_en <= 1'b0;
         r_ldout  <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_ld     <= 1'b0;
         r_sh     <= 1'b0;
         r_cnt_en <= 1'b0;
         r_ldout  <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_LOAD;
                  r_ld    <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               r_state  <= S_CALC;
               r_sh     <= 1'b1;
               r_cnt_en <= 1'b1;
               r_busy   <= 1'b1;
            end
            S_CALC: begin
               r_busy <= 1'b1;
               if (i_co) begin
                  r_state <= S_DONE;
                  r_ldout <= 1'b1;
               end else begin
                  r_sh     <= 1'b1;
                  r_cnt_en <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/shift_add_recombiner_datapath.sv
// Accumulator, shifting multiplicand/multiplier, step counter and result registers.
module recomb_datapath
   import recomb_pkg::*;
#(
   parameter int QW = QW_DEF,
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF,
   parameter int WW = WW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_ld,
   input  logic          i_add_en,
   input  logic          i_sh,
   input  logic          i_cnt_en,
   input  logic          i_ldout,
   input  logic [QW-1:0] i_quo,
   input  logic [DW-1:0] i_d,
   input  logic [RW-1:0] i_rem,
   output logic          o_co,
   output logic          o_q0,
   output logic [WW-1:0] o_w,
   output logic          o_ov
);
   localparam int ACCW = acc_width(QW, DW, RW);
   localparam int MW   = DW + QW;
   localparam int CW   = cnt_width(QW);

   logic [ACCW-1:0] r_acc;
   logic [MW-1:0]   r_mcand;
   logic [QW-1:0]   r_mplier;
   logic [CW-1:0]   r_cnt;
   logic [WW-1:0]   r_w;
   logic            r_ov;

   assign o_co = (r_cnt == CW'(QW - 1));
   assign o_q0 = r_mplier[0];
   assign o_w  = r_w;
   assign o_ov = r_ov;

   // Operand capture, one shift-add step per CALC cycle, result latch in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_w      <= '0;
         r_ov     <= 1'b0;
      end else begin
         if (i_ld) begin
            r_acc    <= ACCW'(i_rem);
            r_mcand  <= MW'(i_d);
            r_mplier <= i_quo;
            r_cnt    <= '0;
         end else begin
            if (i_add_en) r_acc <= r_acc + ACCW'(r_mcand);
            if (i_sh) begin
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
            end
            if (i_cnt_en) r_cnt <= r_cnt + CW'(1);
         end
         if (i_ldout) begin
            r_w  <= WW'(r_acc);
            r_ov <= ((r_acc >> WW) != '0);
         end
      end
   end
endmodule

// File: rtl/shift_add_recombiner.sv
// Rebuilds w = quo*d + rem by sequential shift-add; controller plus datapath.
module shift_add_recombiner
   import recomb_pkg::*;
#(
   parameter int QW = QW_DEF,
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF,
   parameter int WW = WW_DEF
) (
   input logic                  clk,
   input logic                  rst,
   shift_add_recombiner_if.slave bus
);
   logic w_ld, w_add_en, w_sh, w_cnt_en, w_ldout, w_co, w_q0;

   recomb_controller u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .i_start  (bus.start),
      .i_co     (w_co),
      .i_q0     (w_q0),
      .o_ld     (w_ld),
      .o_add_en (w_add_en),
      .o_sh     (w_sh),
      .o_cnt_en (w_cnt_en),
      .o_ldout  (w_ldout),
      .o_done   (bus.done),
      .o_busy   (bus.busy),
      .o_pss    (bus.pss)
   );

   recomb_datapath #(.QW(QW), .DW(DW), .RW(RW), .WW(WW)) u_dp (
      .clk      (clk),
      .rst      (rst),
      .i_ld     (w_ld),
      .i_add_en (w_add_en),
      .i_sh     (w_sh),
      .i_cnt_en (w_cnt_en),
      .i_ldout  (w_ldout),
      .i_quo    (bus.quo),
      .i_d      (bus.d),
      .i_rem    (bus.rem),
      .o_co     (w_co),
      .o_q0     (w_q0),
      .o_w      (bus.w),
      .o_ov     (bus.ov)
   );
endmodule

// File: tb/tb_shift_add_recombiner.sv
module tb_shift_add_recombiner;
   import recomb_pkg::*;

   localparam int QW = 5;
   localparam int DW = 5;
   localparam int RW = 6;
   localparam int WW = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   shift_add_recombiner_if #(.QW(QW), .DW(DW), .RW(RW), .WW(WW)) bus ();

   shift_add_recombiner #(.QW(QW), .DW(DW), .RW(RW), .WW(WW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [WW-1:0] w;
      logic          ov;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic exp_t model(input int q, input int dv, input int r);
      exp_t e;
      int   s;
      s    = q * dv + r;
      e.w  = WW'(s % (1 << WW));
      e.ov = (s >= (1 << WW));
      return e;
   endfunction

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && bus.done === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_done: got w=%0d ov=%0b, required no done", bus.w, bus.ov);
         end else begin
            e = exp_q.pop_front();
            if (bus.w !== e.w || bus.ov !== e.ov) begin
               bad++;
               $display("FAIL sb_result: got w=%0d ov=%0b, required w=%0d ov=%0b",
                        bus.w, bus.ov, e.w, e.ov);
            end
         end
      end
   end

   // Returns at the negedge following the edge that samples start.
   task automatic start_op(input int q, input int dv, input int r);
      @(negedge clk);
      bus.quo   = QW'(q);
      bus.d     = DW'(dv);
      bus.rem   = RW'(r);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done in 30 cycles, required done");
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.quo   = '0;
      bus.d     = '0;
      bus.rem   = '0;
      repeat (3) @(negedge clk);
      total++; if (bus.pss !== 4'd0) begin bad++; $display("FAIL reset_pss: got %0d, required 0", bus.pss); end
      total++; if (bus.w !== '0) begin bad++; $display("FAIL reset_w: got %0d, required 0", bus.w); end
      total++; if (bus.ov !== 1'b0) begin bad++; $display("FAIL reset_ov: got %0b, required 0", bus.ov); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b, required 0", bus.done); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b, required 0", bus.busy); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      int busy_low;
      lat      = -1;
      busy_low = 0;
      exp_q.push_back(model(12, 5, 3));
      start_op(12, 5, 3);
      if (bus.busy !== 1'b1) busy_low++;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            lat = k;
            break;
         end
         if (bus.busy !== 1'b1) busy_low++;
      end
      total++; if (lat !== 7) begin bad++; $display("FAIL basic_latency: got %0d, required 7", lat); end
      total++; if (busy_low !== 0) begin bad++; $display("FAIL basic_busy: got %0d low cycles, required 0", busy_low); end
      total++; if (bus.w !== 10'd63) begin bad++; $display("FAIL basic_w: got %0d, required 63", bus.w); end
   endtask

   task automatic test_boundaries();
      int lat;
      int cases [4][3] = '{'{31, 31, 63}, '{31, 31, 62}, '{17, 0, 9}, '{0, 13, 5}};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(model(cases[i][0], cases[i][1], cases[i][2]));
         start_op(cases[i][0], cases[i][1], cases[i][2]);
         wait_done(lat);
      end
      total++; if (bus.w !== 10'd5 || bus.ov !== 1'b0) begin bad++; $display("FAIL quo_zero: got w=%0d ov=%0b, required w=5 ov=0", bus.w, bus.ov); end
   endtask

   task automatic test_back_to_back();
      int n;
      int t;
      int last;
      int gap_bad;
      n       = 0;
      last    = 0;
      gap_bad = 0;
      for (int i = 0; i < 3; i++) exp_q.push_back(model(3, 4, 1));
      @(negedge clk);
      bus.quo   = 5'd3;
      bus.d     = 5'd4;
      bus.rem   = 6'd1;
      bus.start = 1'b1;
      for (t = 1; t <= 60; t++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            n++;
            if (n > 1 && (t - last) != 8) gap_bad++;
            last = t;
            if (n == 3) begin
               bus.start = 1'b0;
               break;
            end
         end
      end
      bus.start = 1'b0;
      total++; if (n !== 3) begin bad++; $display("FAIL b2b_count: got %0d dones, required 3", n); end
      total++; if (gap_bad !== 0) begin bad++; $display("FAIL b2b_spacing: got %0d bad gaps, required 0", gap_bad); end
      repeat (3) @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_no_extra: got busy=%0b, required 0", bus.busy); end
   endtask

   task automatic test_input_change();
      int lat;
      exp_q.push_back(model(12, 5, 3));
      start_op(12, 5, 3);
      repeat (2) @(negedge clk);
      bus.quo = 5'd7;
      bus.d   = 5'd31;
      bus.rem = 6'd0;
      wait_done(lat);
      total++; if (bus.w !== 10'd63) begin bad++; $display("FAIL input_change_w: got %0d, required 63", bus.w); end
   endtask

   task automatic test_reset_mid();
      int lat;
      start_op(9, 9, 0);
      repeat (3) @(negedge clk);
      total++; if (bus.pss !== 4'd2) begin bad++; $display("FAIL midrst_in_calc: got pss=%0d, required 2", bus.pss); end
      rst = 1'b1;
      @(negedge clk);
      total++; if (bus.pss !== 4'd0) begin bad++; $display("FAIL midrst_pss: got %0d, required 0", bus.pss); end
      total++; if (bus.w !== '0) begin bad++; $display("FAIL midrst_w: got %0d, required 0", bus.w); end
      total++; if (bus.ov !== 1'b0) begin bad++; $display("FAIL midrst_ov: got %0b, required 0", bus.ov); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %0b, required 0", bus.done); end
      rst = 1'b0;
      exp_q.push_back(model(5, 6, 7));
      start_op(5, 6, 7);
      wait_done(lat);
      total++; if (lat !== 7) begin bad++; $display("FAIL post_rst_latency: got %0d, required 7", lat); end
   endtask

   task automatic test_loopback();
      int   lat;
      int   maxw;
      int   wv;
      exp_t e;
      for (int dv = 1; dv <= 31; dv++) begin
         maxw = (32 * dv - 1 < 1023) ? 32 * dv - 1 : 1023;
         for (int j = 0; j < 8; j++) begin
            if (j == 0) wv = maxw;
            else if (j == 1) wv = 0;
            else wv = int'($urandom_range(maxw, 0));
            e.w  = WW'(wv);
            e.ov = 1'b0;
            exp_q.push_back(e);
            start_op(wv / dv, dv, wv % dv);
            wait_done(lat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_back_to_back();
      test_input_change();
      test_reset_mid();
      test_loopback();
      repeat (3) @(negedge clk);
      total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
